// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared types and constants for the digital clock time-setting control.
//   Contents:
//     set_state_t  - RUN / SET_HH / SET_MM / SET_SS / COMMIT sequencer states
//     field_sel_t  - field currently being edited (none, hours, minutes, seconds)
//     KEY_*        - bit positions of each key inside the 3-bit key bus
//     isSetState   - true for the three editing states
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        SET_SS = 3'd3,
        COMMIT = 3'd4
    } set_state_t;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HH   = 2'd1,
        FLD_MM   = 2'd2,
        FLD_SS   = 2'd3
    } field_sel_t;

    localparam int KEY_MODE = 2;
    localparam int KEY_INC  = 1;
    localparam int KEY_DEC  = 0;

    function automatic logic isSetState(input set_state_t s);
        return (s == SET_HH) || (s == SET_MM) || (s == SET_SS);
    endfunction

endpackage

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
//   Brings one asynchronous active-low key into the clock domain and turns
//   its falling edge into a single-cycle press. A press is visible three
//   cycles after the pin falls; holding the key never produces a second one.
//   Ports:
//     clk      in   clock
//     reset    in   synchronous, active-high reset
//     i_key_n  in   raw active-low key pin
//     o_held   out  1 while the synchronized key is pressed (level)
//     o_press  out  one-cycle pulse per press
// -----------------------------------------------------------------------------
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_held,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;

    // Two-flop synchronizer followed by a registered falling-edge detect.
    // Everything resets to the released level so leaving reset never looks
    // like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_prev & ~r_sync2;
        end
    end

    assign o_held  = ~r_sync2;
    assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   Time-setting sequencer for the digital clock. The mode key walks
//   RUN -> SET_HH -> SET_MM -> SET_SS -> COMMIT -> RUN; inc/dec keys in a SET
//   state emit one-cycle pulses to the counter bank. An idle SET state
//   auto-commits after TIMEOUT_S seconds, and the edited field blinks.
//   Optional build macro: TIME_SET_REPEAT_EN adds auto-repeat for held
//   inc/dec keys (first repeat after CLK_HZ/2, then every CLK_HZ/8 cycles).
//   Ports:
//     clk         in   clock
//     reset       in   synchronous, active-high reset
//     key_n[2:0]  in   active-low keys: [2]=mode, [1]=inc, [0]=dec
//     run_en      out  1 when the datapath may count time (RUN only)
//     set_active  out  1 in SET_HH/SET_MM/SET_SS
//     field_sel   out  0=none, 1=HH, 2=MM, 3=SS
//     inc_pulse   out  one-cycle increment request
//     dec_pulse   out  one-cycle decrement request
//     commit      out  one-cycle pulse when editing ends
//     blink_on    out  1 = show the selected field, 0 = blank it
// -----------------------------------------------------------------------------
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 100000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] key_n,
    output logic       run_en,
    output logic       set_active,
    output logic [1:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       commit,
    output logic       blink_on
);

    localparam int TMO_CYCLES = CLK_HZ * TIMEOUT_S;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam int HALF_CYCLES = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLK_W       = $clog2(HALF_CYCLES + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF_CYCLES - 1);

    set_state_t       r_state;
    set_state_t       w_nextState;
    logic [2:0]       w_held;
    logic [2:0]       w_press;
    logic             w_inSet;
    logic             w_nextInSet;
    logic             w_setEntry;
    logic             w_modePress;
    logic             w_incPress;
    logic             w_decPress;
    logic             w_incFire;
    logic             w_decFire;
    logic             w_timeout;
    logic             w_unusedHeld;
    logic [TMO_W-1:0] r_tmoCnt;
    logic [BLK_W-1:0] r_blkCnt;
    logic             r_blink;
    logic             r_incPulse;
    logic             r_decPulse;

    for (genvar g = 0; g < 3; g++) begin : g_key
        key_edge u_keyEdge (
            .clk     (clk),
            .reset   (reset),
            .i_key_n (key_n[g]),
            .o_held  (w_held[g]),
            .o_press (w_press[g])
        );
    end

    // Key arbitration: mode beats inc/dec, and inc+dec together cancel.
    // A press that lands on the last timeout count keeps the edit open.
    always_comb begin
        w_inSet     = isSetState(r_state);
        w_modePress = w_press[KEY_MODE];
        w_incPress  = w_inSet & w_press[KEY_INC] & ~w_press[KEY_DEC] & ~w_modePress;
        w_decPress  = w_inSet & w_press[KEY_DEC] & ~w_press[KEY_INC] & ~w_modePress;
        w_timeout   = (r_tmoCnt == TMO_LAST) & ~(|w_press);
    end

    // Next-state logic for the mode sequence.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (w_modePress) w_nextState = SET_HH;
            SET_HH:  if (w_modePress) w_nextState = SET_MM;
                     else if (w_timeout) w_nextState = COMMIT;
            SET_MM:  if (w_modePress) w_nextState = SET_SS;
                     else if (w_timeout) w_nextState = COMMIT;
            SET_SS:  if (w_modePress || w_timeout) w_nextState = COMMIT;
            COMMIT:  w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
        w_nextInSet = isSetState(w_nextState);
        w_setEntry  = w_nextInSet && (w_nextState != r_state);
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        run_en     = (r_state == RUN);
        set_active = w_inSet;
        commit     = (r_state == COMMIT);
        case (r_state)
            SET_HH:  field_sel = FLD_HH;
            SET_MM:  field_sel = FLD_MM;
            SET_SS:  field_sel = FLD_SS;
            default: field_sel = FLD_NONE;
        endcase
    end

`ifdef TIME_SET_REPEAT_EN
    localparam int REP_FIRST = CLK_HZ / 2;
    localparam int REP_NEXT  = CLK_HZ / 8;
    localparam int REP_W     = $clog2(REP_FIRST + 1);

    logic             r_repActive;
    logic             r_repIsInc;
    logic             r_repRepeating;
    logic [REP_W-1:0] r_repCnt;
    logic [REP_W-1:0] w_repLimit;
    logic             w_repHeld;
    logic             w_repFire;

    // The repeat counter is loaded with 1 on the press so that it equals the
    // number of cycles since the press; after the first repeat it restarts
    // at 0 and fires on each shorter period.
    always_comb begin
        w_unusedHeld = w_held[KEY_MODE];
        w_repHeld    = r_repIsInc ? w_held[KEY_INC] : w_held[KEY_DEC];
        w_repLimit   = r_repRepeating ? REP_W'(REP_NEXT - 1) : REP_W'(REP_FIRST - 1);
        w_repFire    = r_repActive & w_repHeld & (r_repCnt == w_repLimit) & w_inSet
                     & (w_nextState == r_state) & ~w_incPress & ~w_decPress;
        w_incFire    = w_incPress | (w_repFire & r_repIsInc);
        w_decFire    = w_decPress | (w_repFire & ~r_repIsInc);
    end

    // Repeat tracking stops on release or on any state change.
    always_ff @(posedge clk) begin
        if (reset || !w_nextInSet || (w_nextState != r_state)) begin
            r_repActive    <= 1'b0;
            r_repIsInc     <= 1'b0;
            r_repRepeating <= 1'b0;
            r_repCnt       <= '0;
        end else if (w_incPress || w_decPress) begin
            r_repActive    <= 1'b1;
            r_repIsInc     <= w_incPress;
            r_repRepeating <= 1'b0;
            r_repCnt       <= REP_W'(1);
        end else if (!w_repHeld) begin
            r_repActive    <= 1'b0;
        end else if (w_repFire) begin
            r_repRepeating <= 1'b1;
            r_repCnt       <= '0;
        end else if (r_repActive) begin
            r_repCnt       <= r_repCnt + 1'b1;
        end
    end
`else
    // Without auto-repeat every pulse comes from exactly one press, and the
    // held levels have no consumer.
    always_comb begin
        w_unusedHeld = &w_held;
        w_incFire    = w_incPress;
        w_decFire    = w_decPress;
    end
`endif

    // State register; reset drops any edit in progress without a commit.
    always_ff @(posedge clk) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_nextState;
    end

    // Pulses appear the cycle after the press (or repeat) that caused them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_incPulse <= 1'b0;
            r_decPulse <= 1'b0;
        end else begin
            r_incPulse <= w_incFire;
            r_decPulse <= w_decFire;
        end
    end

    // Inactivity timer: runs only while editing, restarts on each new field
    // and on any key activity.
    always_ff @(posedge clk) begin
        if (reset || !w_nextInSet || w_setEntry || (|w_press) || w_incFire || w_decFire)
            r_tmoCnt <= '0;
        else
            r_tmoCnt <= r_tmoCnt + 1'b1;
    end

    // Blink generator: solid outside editing, restarts visible on field entry
    // and after each value change so the user sees the new value at once.
    always_ff @(posedge clk) begin
        if (reset || !w_nextInSet || w_setEntry || w_incFire || w_decFire) begin
            r_blkCnt <= '0;
            r_blink  <= 1'b1;
        end else if (r_blkCnt == BLK_LAST) begin
            r_blkCnt <= '0;
            r_blink  <= ~r_blink;
        end else begin
            r_blkCnt <= r_blkCnt + 1'b1;
        end
    end

    assign inc_pulse = r_incPulse;
    assign dec_pulse = r_decPulse;
    assign blink_on  = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Directed self-checking bench for time_set_ctrl with CLK_HZ=1000,
//   BLINK_HZ=2, TIMEOUT_S=1. Expected inc/dec/commit pulses are queued with
//   the cycle they are due; every cycle the observed pulses are matched
//   against that queue. Level outputs are checked at chosen points.
//   Define TIME_SET_REPEAT_EN to also exercise auto-repeat.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;
    import clock_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic       run_en;
    logic       set_active;
    logic [1:0] field_sel;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       commit;
    logic       blink_on;

    localparam int K_INC    = 0;
    localparam int K_DEC    = 1;
    localparam int K_COMMIT = 2;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    exp_t expQ[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .CLK_HZ    (1000),
        .BLINK_HZ  (2),
        .TIMEOUT_S (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .run_en     (run_en),
        .set_active (set_active),
        .field_sel  (field_sel),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .commit     (commit),
        .blink_on   (blink_on)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input int at);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        expQ.push_back(e);
    endtask

    // One clock step, sampled 1 time unit after the rising edge, with the
    // pulse scoreboard consulted for each pulse output.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            logic  obs;
            int    idx;
            string nm;
            case (k)
                K_INC:   begin obs = inc_pulse; nm = "inc_pulse"; end
                K_DEC:   begin obs = dec_pulse; nm = "dec_pulse"; end
                default: begin obs = commit;    nm = "commit";    end
            endcase
            idx = -1;
            for (int i = 0; i < expQ.size(); i++)
                if (expQ[i].kind == k && expQ[i].cyc == cyc) idx = i;
            if (obs !== 1'b0 || idx >= 0) begin
                checks++;
                assert (obs === (idx >= 0)) else begin
                    errors++;
                    $error("[TB] FAIL %s: observed %0b expected %0b at cycle %0d", nm, obs, (idx >= 0), cyc);
                end
                if (idx >= 0) expQ.delete(idx);
            end
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) tick();
    endtask

    // Press the keys in mask (1 = pressed) for hold cycles, then release and
    // let the synchronizers settle.
    task automatic applyStimulus(input logic [2:0] mask, input int hold);
        key_n = ~mask;
        repeat (hold) tick();
        key_n = 3'b111;
        repeat (4) tick();
    endtask

    initial begin
        int n;
        int e;

        // Reset and idle state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_run_en",     run_en,     1);
        checkOutput("reset_set_active", set_active, 0);
        checkOutput("reset_field_sel",  field_sel,  0);
        checkOutput("reset_blink_on",   blink_on,   1);
        checkOutput("reset_commit",     commit,     0);

        // inc in RUN is ignored
        applyStimulus(3'b010, 5);
        repeat (5) tick();
        checkOutput("run_inc_field_sel", field_sel, 0);
        checkOutput("run_inc_run_en",    run_en,    1);

        // Full mode walk
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(3'b100, 5);
            checkOutput("walk_field_sel",  field_sel,  i);
            checkOutput("walk_run_en",     run_en,     0);
            checkOutput("walk_set_active", set_active, 1);
        end
        n = cyc;
        pushExp(K_COMMIT, n + 4);
        key_n = 3'b011;
        waitUntil(n + 4);
        checkOutput("walk_commit_level", commit,    1);
        checkOutput("walk_commit_runen", run_en,    0);
        checkOutput("walk_commit_field", field_sel, 0);
        tick();
        checkOutput("walk_after_run_en", run_en, 1);
        checkOutput("walk_after_commit", commit, 0);
        key_n = 3'b111;
        repeat (4) tick();

        // SET_MM: hold inc 50 cycles -> one pulse; then a dec press
        applyStimulus(3'b100, 5);
        applyStimulus(3'b100, 5);
        checkOutput("mm_field_sel", field_sel, 2);
        n = cyc;
        pushExp(K_INC, n + 4);
        key_n = 3'b101;
        repeat (50) tick();
        key_n = 3'b111;
        repeat (6) tick();
        checkOutput("hold_inc_queue_empty", expQ.size(), 0);
        pushExp(K_DEC, cyc + 4);
        applyStimulus(3'b001, 5);
        checkOutput("dec_field_sel", field_sel, 2);

        // Leave editing through SET_SS and COMMIT
        applyStimulus(3'b100, 5);
        checkOutput("ss_field_sel", field_sel, 3);
        pushExp(K_COMMIT, cyc + 4);
        applyStimulus(3'b100, 5);
        checkOutput("exit_run_en", run_en, 1);

        // SET_HH idle: blink every 250 cycles, timeout commit after 1000
        n = cyc;
        e = n + 4;
        pushExp(K_COMMIT, e + 1000);
        key_n = 3'b011;
        waitUntil(e);
        key_n = 3'b111;
        checkOutput("tmo_entry_field", field_sel, 1);
        checkOutput("tmo_entry_blink", blink_on,  1);
        waitUntil(e + 249);
        checkOutput("blink_249", blink_on, 1);
        waitUntil(e + 250);
        checkOutput("blink_250", blink_on, 0);
        waitUntil(e + 499);
        checkOutput("blink_499", blink_on, 0);
        waitUntil(e + 500);
        checkOutput("blink_500", blink_on, 1);
        waitUntil(e + 750);
        checkOutput("blink_750", blink_on, 0);
        waitUntil(e + 999);
        checkOutput("tmo_999_field",  field_sel, 1);
        checkOutput("tmo_999_run_en", run_en,    0);
        waitUntil(e + 1000);
        checkOutput("tmo_commit_field", field_sel, 0);
        checkOutput("tmo_commit_blink", blink_on,  1);
        checkOutput("tmo_commit_runen", run_en,    0);
        tick();
        checkOutput("tmo_after_run_en", run_en, 1);

        // Simultaneous keys
        applyStimulus(3'b100, 5);
        checkOutput("sim_hh_field", field_sel, 1);
        applyStimulus(3'b110, 5);
        checkOutput("sim_mode_inc_field", field_sel, 2);
        applyStimulus(3'b011, 5);
        checkOutput("sim_inc_dec_field", field_sel, 2);

        // Reset in SET_SS abandons the edit
        applyStimulus(3'b100, 5);
        checkOutput("rst_ss_field", field_sel, 3);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_field",  field_sel,  0);
        checkOutput("rst_mid_run_en", run_en,     1);
        checkOutput("rst_mid_set",    set_active, 0);
        checkOutput("rst_mid_commit", commit,     0);
        checkOutput("rst_mid_blink",  blink_on,   1);
        reset = 1'b0;
        repeat (20) tick();
        checkOutput("rst_after_run_en", run_en, 1);

`ifdef TIME_SET_REPEAT_EN
        // Auto-repeat: press at n+3, pulses at +1, +500, +625 from the press
        applyStimulus(3'b100, 5);
        n = cyc;
        pushExp(K_INC, n + 4);
        pushExp(K_INC, n + 503);
        pushExp(K_INC, n + 628);
        key_n = 3'b101;
        repeat (700) tick();
        key_n = 3'b111;
        repeat (10) tick();
        checkOutput("rep_field_sel", field_sel, 1);
        applyStimulus(3'b100, 5);
        applyStimulus(3'b100, 5);
        pushExp(K_COMMIT, cyc + 4);
        applyStimulus(3'b100, 5);
        checkOutput("rep_exit_run_en", run_en, 1);
`endif

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
